// File: rtl/cnt_down_sec_min_hr.sv
// Loadable hr:min:sec countdown timer with a one-second prescaler.
// It raises a one-cycle done pulse on reaching 00:00:00 and a one-cycle load_err pulse on a rejected preset.
module cnt_down_sec_min_hr #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] load_sec,
  input  logic [5:0] load_min,
  input  logic [4:0] load_hr,
  input  logic       start,
  input  logic       pause,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hr,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t          state, state_n;
  logic [5:0]      sec_n, min_n;
  logic [4:0]      hr_n;
  logic [PW-1:0]   presc, presc_n;
  logic            done_n, err_n;
  logic            load_ok, nonzero, last, tick;

  assign load_ok = (load_sec <= 6'd59) && (load_min <= 6'd59) && (load_hr <= 5'd23);
  assign nonzero = (sec != 6'd0) || (min != 6'd0) || (hr != 5'd0);
  assign last    = (sec == 6'd1) && (min == 6'd0) && (hr == 5'd0);
  assign tick    = (presc == PMAX);
  assign running = (state == RUN);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sec      <= 6'd0;
      min      <= 6'd0;
      hr       <= 5'd0;
      presc    <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      sec      <= sec_n;
      min      <= min_n;
      hr       <= hr_n;
      presc    <= presc_n;
      done     <= done_n;
      load_err <= err_n;
    end
  end

  // Next-state, load handling and borrow-chain decrement
  always_comb begin
    state_n = state;
    sec_n   = sec;
    min_n   = min;
    hr_n    = hr;
    presc_n = presc;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE, PAUSE: begin
        if (load) begin
          if (load_ok) begin
            sec_n   = load_sec;
            min_n   = load_min;
            hr_n    = load_hr;
            presc_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end else if (start && nonzero) begin
          // A zero count (also a zero preset loaded while paused) never enters RUN.
          state_n = RUN;
        end
      end
      RUN: begin
        if (pause) begin
          state_n = PAUSE;
        end else if (tick) begin
          presc_n = '0;
          if (sec != 6'd0) begin
            sec_n = sec - 6'd1;
          end else begin
            sec_n = 6'd59;
            if (min != 6'd0) begin
              min_n = min - 6'd1;
            end else begin
              min_n = 6'd59;
              hr_n  = hr - 5'd1;
            end
          end
          if (last) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cnt_down_sec_min_hr.sv
// Self-checking bench for cnt_down_sec_min_hr: table-driven vectors for TICK_DIV=1 and a
// hand-written pause/resume sequence for TICK_DIV=4, checked through a scoreboard queue.
module tb_cnt_down_sec_min_hr;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [5:0] ls;
    logic [5:0] lm;
    logic [4:0] lh;
    logic       st;
    logic       pa;
    logic [5:0] es;
    logic [5:0] em;
    logic [4:0] eh;
    logic       er;
    logic       ed;
    logic       ee;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [5:0] load_sec;
  logic [5:0] load_min;
  logic [4:0] load_hr;
  logic       start;
  logic       pause;
  logic [5:0] sec1, min1, sec4, min4;
  logic [4:0] hr1, hr4;
  logic       running1, done1, load_err1, running4, done4, load_err4;

  int errors = 0;
  int checks = 0;
  int sel = 0;
  vec_t tbl[$];
  vec_t sb[$];

  cnt_down_sec_min_hr #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_sec(load_sec), .load_min(load_min),
    .load_hr(load_hr), .start(start), .pause(pause), .sec(sec1), .min(min1), .hr(hr1),
    .running(running1), .done(done1), .load_err(load_err1)
  );

  cnt_down_sec_min_hr #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_sec(load_sec), .load_min(load_min),
    .load_hr(load_hr), .start(start), .pause(pause), .sec(sec4), .min(min4), .hr(hr4),
    .running(running4), .done(done4), .load_err(load_err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int rst, input int ld, input int ls, input int lm,
                              input int lh, input int st, input int pa, input int es,
                              input int em, input int eh, input int er, input int ed,
                              input int ee);
    vec_t v;
    v.rst = 1'(rst); v.ld = 1'(ld); v.ls = 6'(ls); v.lm = 6'(lm); v.lh = 5'(lh);
    v.st = 1'(st); v.pa = 1'(pa); v.es = 6'(es); v.em = 6'(em); v.eh = 5'(eh);
    v.er = 1'(er); v.ed = 1'(ed); v.ee = 1'(ee);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, then compare one step after the edge
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    rst_n = ~v.rst; load = v.ld; load_sec = v.ls; load_min = v.lm; load_hr = v.lh;
    start = v.st; pause = v.pa;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (sel == 0) begin
      chk({tag, " sec"}, int'(sec1), int'(e.es));
      chk({tag, " min"}, int'(min1), int'(e.em));
      chk({tag, " hr"}, int'(hr1), int'(e.eh));
      chk({tag, " running"}, int'(running1), int'(e.er));
      chk({tag, " done"}, int'(done1), int'(e.ed));
      chk({tag, " load_err"}, int'(load_err1), int'(e.ee));
    end else begin
      chk({tag, " sec"}, int'(sec4), int'(e.es));
      chk({tag, " min"}, int'(min4), int'(e.em));
      chk({tag, " hr"}, int'(hr4), int'(e.eh));
      chk({tag, " running"}, int'(running4), int'(e.er));
      chk({tag, " done"}, int'(done4), int'(e.ed));
      chk({tag, " load_err"}, int'(load_err4), int'(e.ee));
    end
  endtask

  task automatic idle4(input int n, input int es, input int er, input string tag);
    for (int i = 0; i < n; i++) step(mk(0,0,0,0,0,0,0, es,0,0, er,0,0), $sformatf("%s%0d", tag, i));
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; load_sec = '0; load_min = '0; load_hr = '0;
    start = 1'b0; pause = 1'b0;

    //          rst ld ls lm lh st pa   es em eh  run done err
    tbl.push_back(mk(1,0, 0, 0, 0,0,0,   0, 0, 0,  0,0,0));  // reset
    tbl.push_back(mk(0,1, 3, 0, 0,0,0,   3, 0, 0,  0,0,0));  // load 0:00:03
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,   3, 0, 0,  1,0,0));  // start
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,   2, 0, 0,  1,0,0));
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,   1, 0, 0,  1,0,0));
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,   0, 0, 0,  0,1,0));  // terminal
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,   0, 0, 0,  0,0,0));  // done drops
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,   0, 0, 0,  0,0,0));  // start at zero
    tbl.push_back(mk(0,1, 0, 0, 1,0,0,   0, 0, 1,  0,0,0));  // load 1:00:00
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,   0, 0, 1,  1,0,0));
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,  59,59, 0,  1,0,0));  // hour borrow
    tbl.push_back(mk(0,0, 0, 0, 0,0,1,  59,59, 0,  0,0,0));  // pause
    tbl.push_back(mk(0,1, 0, 1, 0,0,0,   0, 1, 0,  0,0,0));  // load 0:01:00 in PAUSE
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,   0, 1, 0,  1,0,0));
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,  59, 0, 0,  1,0,0));  // minute borrow
    tbl.push_back(mk(0,1, 5, 0, 0,0,0,  58, 0, 0,  1,0,0));  // load in RUN ignored
    tbl.push_back(mk(0,0, 0, 0, 0,1,1,  58, 0, 0,  0,0,0));  // start+pause -> PAUSE
    tbl.push_back(mk(0,1, 5, 0, 0,0,0,   5, 0, 0,  0,0,0));  // load 0:00:05
    tbl.push_back(mk(0,1,60, 0, 0,0,0,   5, 0, 0,  0,0,1));  // bad sec
    tbl.push_back(mk(0,1, 0,61, 0,0,0,   5, 0, 0,  0,0,1));  // bad min
    tbl.push_back(mk(0,1, 0, 0,24,0,0,   5, 0, 0,  0,0,1));  // bad hr
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,   5, 0, 0,  0,0,0));  // still paused
    tbl.push_back(mk(0,0, 0, 0, 0,1,1,   5, 0, 0,  1,0,0));  // pause ignored in PAUSE
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,   4, 0, 0,  1,0,0));
    tbl.push_back(mk(0,0, 0, 0, 0,0,1,   4, 0, 0,  0,0,0));
    tbl.push_back(mk(0,1,15,30, 0,0,0,  15,30, 0,  0,0,0));  // load 0:30:15
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,  15,30, 0,  1,0,0));
    tbl.push_back(mk(1,0, 0, 0, 0,0,0,   0, 0, 0,  0,0,0));  // reset mid-run
    tbl.push_back(mk(0,1, 2, 0, 0,0,0,   2, 0, 0,  0,0,0));
    tbl.push_back(mk(0,1, 7, 0, 0,1,0,   7, 0, 0,  0,0,0));  // load+start in IDLE
    tbl.push_back(mk(0,1,60, 0, 0,0,0,   7, 0, 0,  0,0,1));  // bad load in IDLE
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,   7, 0, 0,  1,0,0));
    for (int s = 6; s >= 1; s--) tbl.push_back(mk(0,0,0,0,0,0,0, s,0,0, 1,0,0));
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,   0, 0, 0,  0,1,0));
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,   0, 0, 0,  0,0,0));
    tbl.push_back(mk(0,1,59,59,23,0,0,  59,59,23,  0,0,0));  // max legal preset
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,  59,59,23,  1,0,0));
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,  58,59,23,  1,0,0));

    sel = 0;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("v%0d", i));

    // TICK_DIV=4: pause mid-period, hold, resume with retained prescaler phase
    sel = 1;
    step(mk(1,0, 0,0,0,0,0, 0,0,0, 0,0,0), "d4 reset");
    step(mk(0,1,10,0,0,0,0, 10,0,0, 0,0,0), "d4 load");
    step(mk(0,0, 0,0,0,1,0, 10,0,0, 1,0,0), "d4 start");
    idle4(3, 10, 1, "d4 pre");
    idle4(3, 9, 1, "d4 tick1_");
    step(mk(0,0, 0,0,0,0,1, 9,0,0, 0,0,0), "d4 pause");
    idle4(20, 9, 0, "d4 hold");
    step(mk(0,0, 0,0,0,1,0, 9,0,0, 1,0,0), "d4 resume");
    idle4(1, 9, 1, "d4 r");
    idle4(4, 8, 1, "d4 s8_");
    idle4(4, 7, 1, "d4 s7_");
    idle4(1, 6, 1, "d4 s6_");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnt_down_sec_min_hr.md
Name: cnt_down_sec_min_hr

Overview:
Loadable hr:min:sec countdown timer. It is the down-counting counterpart of the free-running seconds/minutes/hours up-counter in the counter chapter. A preset time is loaded, counted down once per second tick, and a one-cycle done pulse is raised on reaching 00:00:00. It is used as the timeout/alarm engine alongside the time-of-day counter.

Parameters:
TICK_DIV, 1, clock cycles per one-second decrement (>=1); TICK_DIV=1 decrements every clock, for simulation.

Ports:
clk       input   1  system clock; all logic on rising edge
rst_n     input   1  synchronous, active-low reset
load      input   1  load preset from load_hr/load_min/load_sec
load_sec  input   6  preset seconds, legal 0..59
load_min  input   6  preset minutes, legal 0..59
load_hr   input   5  preset hours, legal 0..23
start     input   1  begin or resume counting
pause     input   1  suspend counting
sec       output  6  current seconds, 0..59
min       output  6  current minutes, 0..59
hr        output  5  current hours, 0..23
running   output  1  high while state==RUN
done      output  1  one-cycle pulse when the count reaches 00:00:00
load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (rst_n low at a clk edge): sec=min=hr=0, prescaler=0, state=IDLE, running=0, done=0, load_err=0. Reset overrides everything, including mid-run.
- States:
  - IDLE: stopped.
  - RUN: counting.
  - PAUSE: stopped with the prescaler phase retained.
- Load (IDLE or PAUSE only; ignored in RUN):
  - If load_sec<=59, load_min<=59 and load_hr<=23: registers take the preset on that edge and the prescaler clears to 0.
  - Otherwise: registers unchanged, load_err=1 for the next cycle.
  - A load in PAUSE keeps the state at PAUSE.
- Transitions (priority top-down, evaluated each edge):
  - IDLE: load → handled as above, start ignored that cycle. Else start with a nonzero count → RUN. Else start with count 00:00:00 → stay IDLE, no done. pause is ignored.
  - RUN: pause → PAUSE; pause wins over a simultaneous start. Else a tick taking the count to zero → IDLE.
  - PAUSE: load → handled as above. Else start → RUN. pause is ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1, advancing only in RUN.
  - A tick occurs on the edge where prescaler==TICK_DIV-1; the prescaler then wraps to 0.
  - First decrement happens TICK_DIV edges after the edge entering RUN (TICK_DIV=1: the very next edge).
- Decrement on a tick (borrow chain):
  - sec>0 → sec-1.
  - sec==0 → sec=59 and borrow from min: min>0 → min-1; min==0 → min=59 and hr-1.
  - Counting never reaches hr underflow, because RUN exits at zero.
- Terminal count: on the tick taking the value from 00:00:01 to 00:00:00, state → IDLE.
  - done is registered and is high for exactly the one cycle in which the outputs first show 00:00:00.
  - running falls in that same cycle.
- Outputs are direct register values with no combinational path from inputs. running is decoded from the state register.
- sec and min never exceed 59, and hr never exceeds 23, under any input sequence.

Test Plan:
1. TICK_DIV=1; load 0:00:03 in IDLE, start next cycle → sec reads 2, 1, 0 on the following three edges; done=1 and running=0 in the cycle showing 0; done=0 one cycle later.
2. Borrow: load 1:00:00, start → after the first tick hr=0, min=59, sec=59. Load 0:01:00 → 0:00:59.
3. Invalid load: load_sec=60 (also load_min=61, load_hr=24, each separately) with the count at 0:00:05 → load_err one cycle, count stays 0:00:05, state unchanged.
4. TICK_DIV=4; load 0:00:10, start; pause after 6 cycles (sec=9, prescaler=2); hold 20 cycles → no change. Start → sec=8 exactly 2 cycles later, then every 4 cycles.
5. Edge cases:
   - start with count 0:00:00 → no RUN, no done.
   - load in RUN → ignored.
   - start+pause together in RUN → PAUSE.
   - load+start together in IDLE → count loaded, state stays IDLE.
6. Reset mid-run at count 0:30:15 → the next cycle shows 0:00:00, running=0, done=0; a subsequent load and start counts correctly from the new preset.
